adam_mem_arbiter: RTL and testbench

// - Shares one single-port adam_mem style memory (req/addr/we/be/wdata/rdata, 1-cycle read latency)

---
 rtl/adam_mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_adam_mem_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/adam_mem_arbiter.sv
// adam_mem_arbiter
// Shares one single-port adam_mem style memory (1-cycle read latency) between
// NO_REQS requesters. Round-robin arbitration with optional bounded bus locking.
// Read data is routed back with a per-requester rvalid.
//
// Ports
//   clk, rstn         clock, synchronous active-low reset
//   s_req/s_lock      per-requester request and "keep grant next cycle"
//   s_addr/s_we/s_be/s_wdata  flattened requester payloads, requester i at [i*W +: W]
//   s_gnt             one-hot grant, combinational, same cycle as request
//   s_rvalid/s_rdata  read return, cycle after a granted read; rdata shared
//   mem_*             single-port memory interface
module adam_mem_arbiter #(
    parameter int unsigned NO_REQS    = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_LOCK   = 16
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [NO_REQS-1:0]              s_req,
    input  logic [NO_REQS-1:0]              s_lock,
    input  logic [NO_REQS*ADDR_WIDTH-1:0]   s_addr,
    input  logic [NO_REQS-1:0]              s_we,
    input  logic [NO_REQS*DATA_WIDTH/8-1:0] s_be,
    input  logic [NO_REQS*DATA_WIDTH-1:0]   s_wdata,
    output logic [NO_REQS-1:0]              s_gnt,
    output logic [NO_REQS-1:0]              s_rvalid,
    output logic [DATA_WIDTH-1:0]           s_rdata,
    output logic                            mem_req,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic                            mem_we,
    output logic [DATA_WIDTH/8-1:0]         mem_be,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    input  logic [DATA_WIDTH-1:0]           mem_rdata
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned IDX_WIDTH  = (NO_REQS > 1) ? $clog2(NO_REQS) : 1;
    localparam int unsigned CNT_WIDTH  = $clog2(MAX_LOCK + 1);
    localparam bit          LOCK_EN    = (NO_REQS > 1);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t            state_q, state_d;
    logic [IDX_WIDTH-1:0]   owner_q, owner_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [IDX_WIDTH-1:0]   rr_q, rr_d;
    logic [NO_REQS-1:0]     rvalid_d;

    logic                   gnt_any;
    logic [IDX_WIDTH-1:0]   gnt_idx;
    logic                   hold;
    int unsigned            scan_idx;

    // State, pointer and read-return registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= UNLOCKED;
            owner_q  <= '0;
            cnt_q    <= '0;
            rr_q     <= '0;
            s_rvalid <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            s_rvalid <= rvalid_d;
        end
    end

    // Arbitration, lock FSM next-state and read-return tracking
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        hold     = 1'b0;
        scan_idx = 0;
        s_gnt    = '0;
        rvalid_d = '0;
        state_d  = state_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        rr_d     = rr_q;

        // Round-robin scan starting at the pointer
        for (int unsigned k = 0; k < NO_REQS; k++) begin
            scan_idx = (32'(rr_q) + k) % NO_REQS;
            if (!gnt_any && s_req[scan_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_WIDTH'(scan_idx);
            end
        end

        // A live lock overrides round-robin until the burst limit is reached
        if (LOCK_EN && (state_q == LOCKED) && (cnt_q < CNT_WIDTH'(MAX_LOCK)) && s_req[owner_q]) begin
            hold    = 1'b1;
            gnt_any = 1'b1;
            gnt_idx = owner_q;
        end

        if (!rstn) begin
            gnt_any = 1'b0;
            hold    = 1'b0;
        end

        if (gnt_any) begin
            s_gnt[gnt_idx]    = 1'b1;
            rr_d              = IDX_WIDTH'((32'(gnt_idx) + 1) % NO_REQS);
            rvalid_d[gnt_idx] = !s_we[gnt_idx];
        end

        case (state_q)
            UNLOCKED: begin
                if (gnt_any && s_lock[gnt_idx]) begin
                    state_d = LOCKED;
                    owner_d = gnt_idx;
                    cnt_d   = CNT_WIDTH'(1);
                end
            end
            LOCKED: begin
                if (hold && s_lock[owner_q]) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end else if (!hold && gnt_any && s_lock[gnt_idx]) begin
                    // Lock released this cycle, but the new grantee asks for its own burst
                    owner_d = gnt_idx;
                    cnt_d   = CNT_WIDTH'(1);
                end else begin
                    state_d = UNLOCKED;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = UNLOCKED;
                cnt_d   = '0;
            end
        endcase

        if (!LOCK_EN) begin
            state_d = UNLOCKED;
            cnt_d   = '0;
        end
    end

    // Memory-side mux from the granted requester; zero when idle
    always_comb begin
        mem_req   = |(s_req & s_gnt);
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_wdata = '0;
        if (gnt_any) begin
            mem_addr  = s_addr[32'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_we    = s_we[gnt_idx];
            mem_be    = s_be[32'(gnt_idx)*STRB_WIDTH +: STRB_WIDTH];
            mem_wdata = s_wdata[32'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign s_rdata = mem_rdata;

endmodule

// File: tb/tb_adam_mem_arbiter.sv
// Testbench for adam_mem_arbiter (NO_REQS=2, MAX_LOCK=4).
// Directed per-cycle vectors push expectations into a queue; a monitor pops one
// per cycle at the falling edge and compares grant, memory mux and read return.
module tb_adam_mem_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  s_req, s_lock, s_we;
    logic [63:0] s_addr;
    logic [7:0]  s_be;
    logic [63:0] s_wdata;
    logic [1:0]  s_gnt, s_rvalid;
    logic [31:0] s_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    localparam logic [31:0] WD0 = 32'h0A0A_0A0A;
    localparam logic [31:0] WD1 = 32'h1B1B_1B1B;
    localparam logic [3:0]  BE0 = 4'hF;
    localparam logic [3:0]  BE1 = 4'h3;

    typedef struct packed {
        logic [1:0]  gnt;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [1:0]  rvalid;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc_n = 0;
    logic [1:0]  pend_rv = '0;
    logic [31:0] pend_rd = '0;

    adam_mem_arbiter #(
        .NO_REQS   (2),
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MAX_LOCK  (4)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .s_req    (s_req),
        .s_lock   (s_lock),
        .s_addr   (s_addr),
        .s_we     (s_we),
        .s_be     (s_be),
        .s_wdata  (s_wdata),
        .s_gnt    (s_gnt),
        .s_rvalid (s_rvalid),
        .s_rdata  (s_rdata),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_be   (mem_be),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Read-only memory image: 0x40 holds DEADBEEF, everything else echoes its address
    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEAD_BEEF;
        return {16'hC0DE, a[15:0]};
    endfunction

    always @(posedge clk) begin
        if (mem_req && !mem_we) mem_rdata <= rom(mem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc_n, act, exp);
        end
    endtask

    // One clock cycle of stimulus; eg is the hand-derived expected grant.
    // kill drops rstn after the outputs were sampled so the closing edge resets.
    task automatic cyc(input logic rst_v, input logic [1:0] req, input logic [1:0] lock,
                       input logic [1:0] we, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [1:0] eg, input bit kill);
        exp_t e;
        rstn    = rst_v;
        s_req   = req;
        s_lock  = lock;
        s_we    = we;
        s_addr  = {a1, a0};
        s_be    = {BE1, BE0};
        s_wdata = {WD1, WD0};

        e.gnt    = eg;
        e.addr   = (eg == 2'b01) ? a0    : (eg == 2'b10) ? a1    : 32'h0;
        e.we     = (eg == 2'b01) ? we[0] : (eg == 2'b10) ? we[1] : 1'b0;
        e.be     = (eg == 2'b01) ? BE0   : (eg == 2'b10) ? BE1   : 4'h0;
        e.wdata  = (eg == 2'b01) ? WD0   : (eg == 2'b10) ? WD1   : 32'h0;
        e.rvalid = pend_rv;
        e.rdata  = pend_rd;
        exp_q.push_back(e);

        if (rst_v && !kill && ((eg & ~we) != 2'b00)) begin
            pend_rv = eg & ~we;
            pend_rd = rom(e.addr);
        end else begin
            pend_rv = 2'b00;
            pend_rd = 32'h0;
        end

        if (kill) begin
            @(negedge clk);
            #1 rstn = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("gnt",       32'(s_gnt),    32'(e.gnt));
                chk("mem_req",   32'(mem_req),  32'(|e.gnt));
                chk("mem_addr",  mem_addr,      e.addr);
                chk("mem_we",    32'(mem_we),   32'(e.we));
                chk("mem_be",    32'(mem_be),   32'(e.be));
                chk("mem_wdata", mem_wdata,     e.wdata);
                chk("rvalid",    32'(s_rvalid), 32'(e.rvalid));
                if (e.rvalid != 2'b00) chk("rdata", s_rdata, e.rdata);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rstn    = 1'b0;
        s_req   = 2'b11;
        s_lock  = '0;
        s_we    = '0;
        s_addr  = '0;
        s_be    = '0;
        s_wdata = '0;
        @(posedge clk);
        #1;

        // Reset held with everyone requesting
        cyc(1'b0, 2'b11, 2'b00, 2'b00, 32'h100, 32'h200, 2'b00, 1'b0);
        cyc(1'b0, 2'b11, 2'b00, 2'b00, 32'h100, 32'h200, 2'b00, 1'b0);

        // Round-robin alternation, requester 0 first after reset
        cyc(1'b1, 2'b11, 2'b00, 2'b00, 32'h100, 32'h200, 2'b01, 1'b0);
        cyc(1'b1, 2'b11, 2'b00, 2'b00, 32'h104, 32'h204, 2'b10, 1'b0);
        cyc(1'b1, 2'b11, 2'b00, 2'b00, 32'h108, 32'h208, 2'b01, 1'b0);
        cyc(1'b1, 2'b11, 2'b00, 2'b00, 32'h10C, 32'h20C, 2'b10, 1'b0);

        // Requester 1 reads 0x40, then requester 0 writes while data returns
        cyc(1'b1, 2'b10, 2'b00, 2'b00, 32'h110, 32'h040, 2'b10, 1'b0);
        cyc(1'b1, 2'b01, 2'b00, 2'b01, 32'h300, 32'h210, 2'b01, 1'b0);
        cyc(1'b1, 2'b10, 2'b00, 2'b00, 32'h114, 32'h214, 2'b10, 1'b0);

        // Lock burst capped at MAX_LOCK=4, then forced release to requester 1
        cyc(1'b1, 2'b11, 2'b01, 2'b00, 32'h120, 32'h220, 2'b01, 1'b0);
        cyc(1'b1, 2'b11, 2'b01, 2'b00, 32'h124, 32'h224, 2'b01, 1'b0);
        cyc(1'b1, 2'b11, 2'b01, 2'b00, 32'h128, 32'h228, 2'b01, 1'b0);
        cyc(1'b1, 2'b11, 2'b01, 2'b00, 32'h12C, 32'h22C, 2'b01, 1'b0);
        cyc(1'b1, 2'b11, 2'b01, 2'b00, 32'h130, 32'h230, 2'b10, 1'b0);
        cyc(1'b1, 2'b11, 2'b00, 2'b00, 32'h134, 32'h234, 2'b01, 1'b0);
        cyc(1'b1, 2'b11, 2'b00, 2'b00, 32'h138, 32'h238, 2'b10, 1'b0);

        // Locked owner drops its request after two grants
        cyc(1'b1, 2'b11, 2'b01, 2'b00, 32'h140, 32'h240, 2'b01, 1'b0);
        cyc(1'b1, 2'b11, 2'b01, 2'b00, 32'h144, 32'h244, 2'b01, 1'b0);
        cyc(1'b1, 2'b10, 2'b00, 2'b00, 32'h148, 32'h248, 2'b10, 1'b0);
        cyc(1'b1, 2'b11, 2'b00, 2'b00, 32'h14C, 32'h24C, 2'b01, 1'b0);

        // Mid-operation reset with pointer past requester 0: read lost, pointer cleared
        cyc(1'b1, 2'b01, 2'b01, 2'b00, 32'h150, 32'h250, 2'b01, 1'b1);
        cyc(1'b0, 2'b11, 2'b00, 2'b00, 32'h150, 32'h250, 2'b00, 1'b0);
        cyc(1'b1, 2'b11, 2'b00, 2'b00, 32'h154, 32'h254, 2'b01, 1'b0);

        // Mid-operation reset while requester 1 holds a lock: lock cleared
        cyc(1'b1, 2'b10, 2'b10, 2'b00, 32'h158, 32'h258, 2'b10, 1'b0);
        cyc(1'b1, 2'b11, 2'b10, 2'b00, 32'h15C, 32'h25C, 2'b10, 1'b1);
        cyc(1'b0, 2'b11, 2'b00, 2'b00, 32'h15C, 32'h25C, 2'b00, 1'b0);
        cyc(1'b1, 2'b11, 2'b00, 2'b00, 32'h160, 32'h260, 2'b01, 1'b0);
        cyc(1'b1, 2'b11, 2'b00, 2'b00, 32'h164, 32'h264, 2'b10, 1'b0);
        cyc(1'b1, 2'b00, 2'b00, 2'b00, 32'h168, 32'h268, 2'b00, 1'b0);

        @(negedge clk);
        #1;
        chk("drain", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
